// File: rtl/perf_counter_bank.sv
// Performance counter bank: per-event counters plus a cycle counter, with shadow snapshot and readout.
// Define PERF_SATURATE_EN to make counters saturate at all-ones instead of wrapping.
module perf_counter_bank #(
    parameter int NUM_EVENTS = 6,
    parameter int CNT_WIDTH  = 32,
    parameter int SEL_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  halt,
    input  logic [NUM_EVENTS-1:0] event_i,
    input  logic                  clear,
    input  logic                  snap,
    input  logic [SEL_W-1:0]      rd_sel,
    output logic [CNT_WIDTH-1:0]  rd_data,
    output logic                  rd_ovf,
    output logic                  frozen,
    output logic                  snap_valid
);
    // Channel NUM_EVENTS is the free-running cycle counter.
    localparam int NCH = NUM_EVENTS + 1;
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_FROZEN = 1'b1;
    localparam logic [CNT_WIDTH-1:0] ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [0:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q [NCH], cnt_d [NCH], cnt_inc [NCH];
    logic [CNT_WIDTH-1:0] shd_q [NCH], shd_d [NCH];
    logic [NCH-1:0]       ovf_q, ovf_d, ovf_inc;
    logic [NCH-1:0]       shd_ovf_q, shd_ovf_d;
    logic                 snap_valid_q, snap_valid_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_ovf_q, rd_ovf_d;
    logic [NCH-1:0]       tick;
    logic                 count_en, halt_take, capture;

    assign count_en  = (state_q == ST_RUN) && en;
    assign halt_take = count_en && halt && !clear;
    assign capture   = snap || halt_take;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_tick
            if (gi == NUM_EVENTS) begin : g_cycle
                assign tick[gi] = count_en;
            end else begin : g_event
                assign tick[gi] = count_en & event_i[gi];
            end
        end
    endgenerate

    // cnt_inc is the post-count, pre-clear value: snapshots see the current cycle's events.
    always_comb begin
        for (int k = 0; k < NCH; k++) begin
            cnt_inc[k] = cnt_q[k];
            ovf_inc[k] = ovf_q[k];
            if (tick[k]) begin
                if (&cnt_q[k]) begin
                    ovf_inc[k] = 1'b1;
`ifdef PERF_SATURATE_EN
                    cnt_inc[k] = cnt_q[k];
`else
                    cnt_inc[k] = '0;
`endif
                end else begin
                    cnt_inc[k] = cnt_q[k] + ONE;
                end
            end
            cnt_d[k]     = clear ? '0 : cnt_inc[k];
            ovf_d[k]     = clear ? 1'b0 : ovf_inc[k];
            shd_d[k]     = capture ? cnt_inc[k] : shd_q[k];
            shd_ovf_d[k] = capture ? ovf_inc[k] : shd_ovf_q[k];
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_RUN;
        end else if (halt_take) begin
            state_d = ST_FROZEN;
        end

        snap_valid_d = snap_valid_q;
        if (capture) begin
            snap_valid_d = 1'b1;
        end else if (clear) begin
            snap_valid_d = 1'b0;
        end

        rd_data_d = '0;
        rd_ovf_d  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                rd_data_d = shd_q[k];
                rd_ovf_d  = shd_ovf_q[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            ovf_q        <= '0;
            shd_ovf_q    <= '0;
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
            rd_ovf_q     <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= '0;
                shd_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            ovf_q        <= ovf_d;
            shd_ovf_q    <= shd_ovf_d;
            snap_valid_q <= snap_valid_d;
            rd_data_q    <= rd_data_d;
            rd_ovf_q     <= rd_ovf_d;
            for (int k = 0; k < NCH; k++) begin
                cnt_q[k] <= cnt_d[k];
                shd_q[k] <= shd_d[k];
            end
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_ovf     = rd_ovf_q;
    assign frozen     = (state_q == ST_FROZEN);
    assign snap_valid = snap_valid_q;

endmodule
